// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> IMEM words; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned im_size   = 16,
    parameter int unsigned word_size = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [im_size-1:0]   imem_addr,
    output logic [word_size-1:0] imem_wdata,
    output logic                 cpu_rst,
    input  logic                 load,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned CW = im_size + 1;
    localparam int unsigned LW = (CW > 16) ? CW : 16;
    localparam logic [LW-1:0] MAX_LEN = LW'(1) << im_size;

    typedef enum logic [3:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_WORD_HI,
        S_WORD_LO,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t        state;
    logic [7:0]    len_hi;
    logic [7:0]    word_hi;
    logic [CW-1:0] len;
    logic [CW-1:0] count;
    logic [LW-1:0] new_len;
    logic          xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign new_len = LW'({len_hi, in_data});
    assign xfer    = in_valid & in_ready;

    // Ready is a pure state decode, forced low while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_WORD_HI, S_WORD_LO: in_ready = rst_n;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                                   in_ready = rst_n;
`endif
            default:                                  in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_LEN_HI;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len_hi     <= '0;
            word_hi    <= '0;
            len        <= '0;
            count      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (xfer && state != S_CSUM) csum <= csum ^ in_data;
`endif
            case (state)
                S_LEN_HI: if (xfer) begin
                    len_hi <= in_data;
                    state  <= S_LEN_LO;
                end
                S_LEN_LO: if (xfer) begin
                    len <= CW'(new_len);
                    if (new_len > MAX_LEN) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else if (new_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state   <= S_CSUM;
`else
                        state   <= S_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
`endif
                    end else begin
                        state <= S_WORD_HI;
                    end
                end
                S_WORD_HI: if (xfer) begin
                    word_hi <= in_data;
                    state   <= S_WORD_LO;
                end
                S_WORD_LO: if (xfer) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= word_size'({word_hi, in_data});
                    state      <= S_WRITE;
                end
                // Address wraps to 0 after a full-size load; it is never reused.
                S_WRITE: begin
                    imem_addr <= imem_addr + im_size'(1);
                    count     <= count + CW'(1);
                    if (count + CW'(1) == len) begin
`ifdef LOADER_CHECKSUM_EN
                        state   <= S_CSUM;
`else
                        state   <= S_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
`endif
                    end else begin
                        state <= S_WORD_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (xfer) begin
                    if (csum == in_data) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end
                end
`endif
                S_DONE, S_ERR: if (load) begin
                    state     <= S_LEN_HI;
                    cpu_rst   <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    imem_addr <= '0;
                    count     <= '0;
                    len       <= '0;
`ifdef LOADER_CHECKSUM_EN
                    csum      <= '0;
`endif
                end
                default: state <= S_LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (im_size=4 so overflow and full-size boundaries are reachable).
module tb_imem_loader;

    localparam int unsigned IM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [IM-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_rst;
    logic          load;
    logic          done;
    logic          error;

    int         checks = 0;
    int         errors = 0;
    logic [15:0] mem [16];
    int         writes = 0;
    int         overlap = 0;
    int         dbl = 0;
    logic       prev_we = 1'b0;
    logic [7:0] tb_xor = 8'h00;

    imem_loader #(.im_size(IM), .word_size(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .load(load),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // IMEM model plus write-strobe sanity counters.
    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            writes = writes + 1;
        end
    end

    always @(negedge clk) begin
        if (imem_we && in_ready) overlap = overlap + 1;
        if (imem_we && prev_we) dbl = dbl + 1;
        prev_we = imem_we;
    end

    task automatic clear_mon();
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
        writes = 0;
        overlap = 0;
        dbl = 0;
        tb_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_byte_timeout byte=%02h in_ready=%0b required=1", b, in_ready);
        end
        @(posedge clk);
        tb_xor = tb_xor ^ b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_tail();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rearm();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({done, error, cpu_rst, in_ready, imem_addr} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL rearm done/err/cpu_rst/rdy/addr=%b required=0011_0000",
                     {done, error, cpu_rst, in_ready, imem_addr});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h55; load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_rst, done, error, in_ready}
            !== {1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=%h",
                     {imem_we, imem_addr, imem_wdata, cpu_rst, done, error, in_ready},
                     {1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        rst_n = 1'b1; in_valid = 1'b0; load = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, cpu_rst, done} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release rdy/cpu_rst/done=%b required=110", {in_ready, cpu_rst, done});
        end
    endtask

    task automatic test_basic();
        clear_mon();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h40); send_byte(8'h00);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, done} !== {1'b1, 4'h1, 16'h4000, 1'b0}) begin
            errors++;
            $display("FAIL basic_write1 we/addr/wdata/done=%h required=%h",
                     {imem_we, imem_addr, imem_wdata, done}, {1'b1, 4'h1, 16'h4000, 1'b0});
        end
        @(negedge clk);
`ifndef LOADER_CHECKSUM_EN
        checks++;
        if ({done, cpu_rst, imem_we, imem_addr} !== {1'b1, 1'b0, 1'b0, 4'h2}) begin
            errors++;
            $display("FAIL basic_done_latency done/cpu_rst/we/addr=%b required=100_0010",
                     {done, cpu_rst, imem_we, imem_addr});
        end
`endif
        send_tail();
        wait_end();
        checks++;
        if ({done, cpu_rst, error} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done done/cpu_rst/err=%b required=100", {done, cpu_rst, error});
        end
        checks++;
        if ({mem[0], mem[1]} !== {16'h1000, 16'h4000}) begin
            errors++;
            $display("FAIL basic_imem got=%h_%h required=1000_4000", mem[0], mem[1]);
        end
        checks++;
        if (writes !== 2 || dbl !== 0) begin
            errors++;
            $display("FAIL basic_we_count writes=%0d dbl=%0d required=2,0", writes, dbl);
        end
        rearm();
    endtask

    task automatic test_zero_len();
        clear_mon();
        send_byte(8'h00); send_byte(8'h00);
        send_tail();
        wait_end();
        checks++;
        if ({done, cpu_rst, error} !== 3'b100 || writes !== 0) begin
            errors++;
            $display("FAIL zero_len done/cpu_rst/err=%b writes=%0d required=100,0",
                     {done, cpu_rst, error}, writes);
        end
        rearm();
    endtask

    task automatic test_valid_toggle();
        logic [7:0] s [8];
        s = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            send_byte(s[i]);
            @(negedge clk);
        end
        send_tail();
        wait_end();
        checks++;
        if ({mem[0], mem[1], mem[2]} !== {16'h0123, 16'h4567, 16'h89AB}) begin
            errors++;
            $display("FAIL toggle_imem got=%h_%h_%h required=0123_4567_89ab", mem[0], mem[1], mem[2]);
        end
        checks++;
        if (writes !== 3 || overlap !== 0 || dbl !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_strobes writes=%0d overlap=%0d dbl=%0d done=%b required=3,0,0,1",
                     writes, overlap, dbl, done);
        end
        rearm();
    endtask

    task automatic test_overflow();
        clear_mon();
        send_byte(8'h00); send_byte(8'h11);
        checks++;
        if ({error, cpu_rst, done, in_ready} !== 4'b1100 || writes !== 0) begin
            errors++;
            $display("FAIL overflow err/cpu_rst/done/rdy=%b writes=%0d required=1100,0",
                     {error, cpu_rst, done, in_ready}, writes);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold error=%b required=1", error);
        end
        rearm();
    endtask

    task automatic test_full_size();
        clear_mon();
        send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            send_byte(8'(8'hA0 + i));
        end
        send_tail();
        wait_end();
        checks++;
        if ({done, error, imem_addr} !== {1'b1, 1'b0, 4'h0} || writes !== 16) begin
            errors++;
            $display("FAIL full_size done/err/addr=%b writes=%0d required=10_0000,16",
                     {done, error, imem_addr}, writes);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== {8'(i), 8'(8'hA0 + i)}) begin
                errors++;
                $display("FAIL full_imem[%0d] got=%h required=%h", i, mem[i], {8'(i), 8'(8'hA0 + i)});
            end
        end
        rearm();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_mon();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h27);
        wait_end();
        checks++;
        if ({done, error, cpu_rst} !== 3'b100 || mem[0] !== 16'h1234) begin
            errors++;
            $display("FAIL csum_good done/err/cpu_rst=%b imem0=%h required=100,1234",
                     {done, error, cpu_rst}, mem[0]);
        end
        rearm();
        clear_mon();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h26);
        wait_end();
        checks++;
        if ({done, error, cpu_rst} !== 3'b011) begin
            errors++;
            $display("FAIL csum_bad done/err/cpu_rst=%b required=011", {done, error, cpu_rst});
        end
        rearm();
    endtask
`endif

    task automatic test_mid_reset();
        clear_mon();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'hAB);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_rst, done, error, in_ready}
            !== {1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0} || writes !== 0) begin
            errors++;
            $display("FAIL mid_reset got=%h writes=%0d required=%h,0",
                     {imem_we, imem_addr, imem_wdata, cpu_rst, done, error, in_ready}, writes,
                     {1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hCD); send_byte(8'hEF);
        send_tail();
        wait_end();
        checks++;
        if ({done, cpu_rst} !== 2'b10 || mem[0] !== 16'hCDEF || writes !== 1) begin
            errors++;
            $display("FAIL reload done/cpu_rst=%b imem0=%h writes=%0d required=10,cdef,1",
                     {done, cpu_rst}, mem[0], writes);
        end
        rearm();
    endtask

    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; load = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_valid_toggle();
        test_overflow();
        test_full_size();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
